seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Registered, parametrised successor to the combinational datapath ALU.
- Single-cycle ops (logic, shifts, add/sub, SLT, LUI) are computed combinationally and returned one clock later.
- MULT/MULTU/DIV/DIVU run on an iterative engine (XLEN steps) that returns a full 2*XLEN product or a quotient/remainder pair on out/out_hi.
- Sits in the EX stage. The core stalls on in_ready low.

Parameters:
- XLEN, 32: operand/result width; even, >= 8.
- SHW, $clog2(XLEN): shift-amount width, derived; do not override.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- alu_operation  in  5  opcode.
- input1  in  XLEN  operand A; shift amount for shifts.
- input2  in  XLEN  operand B; value shifted for shifts.
- out_valid  out  1  one-cycle pulse, result valid.
- out  out  XLEN  result / product low / quotient.
- out_hi  out  XLEN  product high / remainder; 0 for single-cycle ops.
- zero  out  1  ~|out (registered result).
- negative  out  1  out[XLEN-1].

Behaviour:
- Opcodes:
  - NOP=0 (out=input1), XOR=1, OR=2, AND=3, NOR=4.
  - SLL=5, SRL=6, SLT=7 (signed), ADD=8, ADDU=9, SUB=10, SUBU=11.
  - MULT=12 (signed), DIV=13 (signed), SRA=14.
  - LUI=15 (out = {input2[XLEN/2-1:0], XLEN/2 zeros}).
  - MULTU=16, DIVU=17.
  - Any other opcode: out=0, out_hi=0, single-cycle.
- Shifts use input1[SHW-1:0] only; upper bits are ignored.
- Add/sub wrap modulo 2^XLEN. No overflow flag.
- Reset (rst_n low, async): state=IDLE, in_ready=1, out_valid=0, out=0, out_hi=0; zero=1 and negative=0 as derived from out=0. Any in-flight mul/div is discarded with no out_valid.
- Accept condition: in_valid && in_ready at a rising edge. Opcode and operands are sampled only at accept.
- FSM states: IDLE, MUL, DIV.
- IDLE:
  - in_ready=1.
  - Single-cycle op: accept at edge N loads out/out_hi; out_valid=1 during cycle N+1; state stays IDLE. Back-to-back accepts give one result per cycle.
  - Mul/div op: latches operand magnitudes and result sign(s); loads step counter = XLEN; goes to MUL or DIV.
- MUL:
  - Shift-add, one bit per cycle. in_ready=0.
  - When the counter reaches 0: write product, return to IDLE. Fixed total latency XLEN+1 cycles from the accept edge.
- DIV:
  - Restoring division, one quotient bit per cycle. in_ready=0. Same latency as MUL.
- Result pulse and cadence:
  - out_valid is high exactly one cycle per accepted op.
  - in_ready is already 1 during a mul/div out_valid cycle, so a new op may be accepted at the edge ending that cycle.
- Signed handling: operate on magnitudes, then apply signs.
  - Product sign = sign1 ^ sign2.
  - Quotient sign = sign1 ^ sign2.
  - Remainder sign = sign of dividend.
- Divide by zero, DIV and DIVU: out = all ones, out_hi = dividend unchanged. Latency is unchanged.
- Signed overflow, DIV of MIN by -1: out = MIN, out_hi = 0.
- out, out_hi, zero and negative hold their values between results. They change only on the edge that raises out_valid, or on reset.
- in_valid asserted while in_ready=0 is ignored. The requester must hold it.
- Reset mid-MUL/DIV: next cycle is IDLE with in_ready=1 and no stale out_valid.

Test Plan:
- Reset, then ADD 7+(-3) (XLEN=32) -> out_valid one cycle later, out=4, out_hi=0, zero=0, negative=0.
- Back-to-back SUB 5-5 then SLL input1=36, input2=1 -> two consecutive out_valid pulses; first has out=0, zero=1; second has out=16 (shift amount = 36 mod 32 = 4).
- MULT -2 * 3 -> in_ready low for 32 cycles; out_valid at cycle 33; out=0xFFFFFFFA, out_hi=0xFFFFFFFF. MULTU 0xFFFFFFFF * 2 -> out=0xFFFFFFFE, out_hi=1.
- DIV -7/2 -> out=0xFFFFFFFD (-3), out_hi=0xFFFFFFFF (-1). DIVU 9/0 -> out=0xFFFFFFFF, out_hi=9. DIV 0x80000000/-1 -> out=0x80000000, out_hi=0.
- Accept DIV, deassert rst_n at iteration 10 -> out=0, in_ready=1 immediately; no out_valid ever appears for that op.
- Parameter sweep XLEN=8: MULT 0x7F*0x7F -> out=0x01, out_hi=0x3F after 9 cycles; opcode 20 -> out=0 next cycle.

Source files
------------

// File: rtl/seq_alu.sv
// Registered EX-stage ALU: single-cycle ops return one clock after accept;
// multiply/divide run on a shared XLEN-step shift-add / restoring engine.
module seq_alu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_operation,
  input  logic [XLEN-1:0] input1,
  input  logic [XLEN-1:0] input2,
  output logic            out_valid,
  output logic [XLEN-1:0] out,
  output logic [XLEN-1:0] out_hi,
  output logic            zero,
  output logic            negative
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   p_q, p_d;
  logic [XLEN-1:0]     m_q, m_d;
  logic                sgn_lo_q, sgn_lo_d, sgn_hi_q, sgn_hi_d, dz_q, dz_d;
  logic [XLEN-1:0]     out_q, out_d, out_hi_q, out_hi_d;
  logic                out_valid_q, out_valid_d;

  logic                accept, is_mul, is_div, sgnd, s1, s2;
  logic [XLEN-1:0]     mag1, mag2, sc_res;
  logic [SHW-1:0]      sh;
  logic [XLEN:0]       mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0]   mul_next, div_next, prod_f;
  logic [XLEN-1:0]     quot_f, rem_f;

  assign accept = in_valid && in_ready;
  assign is_mul = (alu_operation == 5'd12) || (alu_operation == 5'd16);
  assign is_div = (alu_operation == 5'd13) || (alu_operation == 5'd17);
  assign sgnd   = (alu_operation == 5'd12) || (alu_operation == 5'd13);
  assign s1     = sgnd & input1[XLEN-1];
  assign s2     = sgnd & input2[XLEN-1];
  assign mag1   = s1 ? -input1 : input1;
  assign mag2   = s2 ? -input2 : input2;
  assign sh     = input1[SHW-1:0];

  always_comb begin
    sc_res = '0;
    case (alu_operation)
      5'd0:  sc_res = input1;
      5'd1:  sc_res = input1 ^ input2;
      5'd2:  sc_res = input1 | input2;
      5'd3:  sc_res = input1 & input2;
      5'd4:  sc_res = ~(input1 | input2);
      5'd5:  sc_res = input2 << sh;
      5'd6:  sc_res = input2 >> sh;
      5'd7:  sc_res = {{(XLEN-1){1'b0}}, $signed(input1) < $signed(input2)};
      5'd8, 5'd9:   sc_res = input1 + input2;
      5'd10, 5'd11: sc_res = input1 - input2;
      5'd14: sc_res = XLEN'($signed(input2) >>> sh);
      5'd15: sc_res = {input2[XLEN/2-1:0], {(XLEN/2){1'b0}}};
      default: sc_res = '0;
    endcase
  end

  // p_q holds {acc, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  assign mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, m_q} : '0);
  assign mul_next = {mul_sum, p_q[XLEN-1:1]};
  assign div_sh   = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, m_q};
  assign div_next = div_diff[XLEN] ? {div_sh[XLEN-1:0], p_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};

  assign prod_f = sgn_lo_q ? -mul_next : mul_next;
  assign quot_f = dz_q ? '1 : (sgn_lo_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0]);
  assign rem_f  = sgn_hi_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && is_mul) state_d = MUL;
            else if (accept && is_div) state_d = DIV;
      MUL, DIV: if (cnt_q == CW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
  end

  always_comb begin
    cnt_d       = cnt_q;
    p_d         = p_q;
    m_d         = m_q;
    sgn_lo_d    = sgn_lo_q;
    sgn_hi_d    = sgn_hi_q;
    dz_d        = dz_q;
    out_d       = out_q;
    out_hi_d    = out_hi_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (is_mul || is_div) begin
          p_d      = {{XLEN{1'b0}}, mag1};
          m_d      = mag2;
          cnt_d    = CW'(XLEN);
          sgn_lo_d = s1 ^ s2;
          sgn_hi_d = s1;
          dz_d     = is_div && (input2 == '0);
        end else begin
          out_d       = sc_res;
          out_hi_d    = '0;
          out_valid_d = 1'b1;
        end
      end
      MUL: begin
        p_d   = mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_d       = prod_f[XLEN-1:0];
          out_hi_d    = prod_f[2*XLEN-1:XLEN];
          out_valid_d = 1'b1;
        end
      end
      DIV: begin
        p_d   = div_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_d       = quot_f;
          out_hi_d    = rem_f;
          out_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      p_q         <= '0;
      m_q         <= '0;
      sgn_lo_q    <= 1'b0;
      sgn_hi_q    <= 1'b0;
      dz_q        <= 1'b0;
      out_q       <= '0;
      out_hi_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      m_q         <= m_d;
      sgn_lo_q    <= sgn_lo_d;
      sgn_hi_q    <= sgn_hi_d;
      dz_q        <= dz_d;
      out_q       <= out_d;
      out_hi_q    <= out_hi_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_hi    = out_hi_q;
  assign out_valid = out_valid_q;
  assign zero      = ~|out_q;
  assign negative  = out_q[XLEN-1];
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed and random ops on a 32-bit instance against an
// arithmetic reference model, plus a small 8-bit instance.
module tb_seq_alu;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  logic iv = 0, ir, ov, z, n;
  logic [4:0] op = 0;
  logic [31:0] a = 0, b = 0, o, oh;

  logic iv8 = 0, ir8, ov8, z8, n8;
  logic [4:0] op8 = 0;
  logic [7:0] a8 = 0, b8 = 0, o8, oh8;

  int errors = 0, checks = 0;

  seq_alu #(.XLEN(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .alu_operation(op),
    .input1(a), .input2(b), .out_valid(ov), .out(o), .out_hi(oh),
    .zero(z), .negative(n));

  seq_alu #(.XLEN(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .alu_operation(op8),
    .input1(a8), .input2(b8), .out_valid(ov8), .out(o8), .out_hi(oh8),
    .zero(z8), .negative(n8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [4:0] opc, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] lo, output logic [31:0] hi);
    longint sx, sy, t;
    logic [63:0] pu;
    sx = $signed(x);
    sy = $signed(y);
    lo = 0;
    hi = 0;
    case (opc)
      0: lo = x;
      1: lo = x ^ y;
      2: lo = x | y;
      3: lo = x & y;
      4: lo = ~(x | y);
      5: lo = y << x[4:0];
      6: lo = y >> x[4:0];
      7: lo = (sx < sy) ? 32'd1 : 32'd0;
      8, 9: lo = x + y;
      10, 11: lo = x - y;
      12: begin t = sx * sy; {hi, lo} = t; end
      16: begin pu = {32'b0, x} * {32'b0, y}; {hi, lo} = pu; end
      13: if (y == 0) begin lo = '1; hi = x; end
          else begin t = sx / sy; lo = t[31:0]; t = sx % sy; hi = t[31:0]; end
      17: if (y == 0) begin lo = '1; hi = x; end
          else begin lo = x / y; hi = x % y; end
      14: begin t = sy >>> x[4:0]; lo = t[31:0]; end
      15: lo = {y[15:0], 16'h0};
      default: ;
    endcase
  endfunction

  // Issue one op from IDLE, wait for its result, check latency, value and pulse.
  task automatic run(input logic [4:0] opc, input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [31:0] el, eh;
    int lat, cyc;
    model(opc, x, y, el, eh);
    lat = (opc inside {5'd12, 5'd13, 5'd16, 5'd17}) ? 33 : 1;
    chk({tag, " ready"}, ir, 1);
    iv = 1; op = opc; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    // hold a junk request during busy cycles: it must be ignored
    iv = (lat > 1); op = 5'($urandom); a = $urandom; b = $urandom;
    cyc = 1;
    if (lat > 1) chk({tag, " busy"}, ir, 0);
    while (!ov && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc >= 20) iv = 0;
    end
    iv = 0;
    chk({tag, " latency"}, cyc, lat);
    chk({tag, " out"}, o, el);
    chk({tag, " out_hi"}, oh, eh);
    chk({tag, " zero"}, z, ~|el);
    chk({tag, " neg"}, n, el[31]);
    @(negedge clk);
    chk({tag, " pulse"}, ov, 0);
    chk({tag, " hold"}, o, el);
  endtask

  initial begin
    int cyc, seen;
    logic [4:0] ro;
    logic [31:0] rx, ry;

    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst out", o, 0);
    chk("rst out_hi", oh, 0);
    chk("rst valid", ov, 0);
    chk("rst ready", ir, 1);
    chk("rst zero", z, 1);
    chk("rst neg", n, 0);
    chk("rst out8", o8, 0);
    rst_n = 1;
    @(negedge clk);

    run(5'd8, 32'd7, -32'sd3, "add");

    chk("b2b ready", ir, 1);
    iv = 1; op = 5'd10; a = 5; b = 5;
    @(posedge clk); @(negedge clk);
    chk("b2b sub valid", ov, 1);
    chk("b2b sub out", o, 0);
    chk("b2b sub zero", z, 1);
    op = 5'd5; a = 36; b = 1;
    @(posedge clk); @(negedge clk);
    chk("b2b sll valid", ov, 1);
    chk("b2b sll out", o, 16);
    chk("b2b sll zero", z, 0);
    iv = 0;
    @(negedge clk);
    chk("b2b pulse", ov, 0);
    chk("b2b hold", o, 16);

    run(5'd12, -32'sd2, 32'd3, "mult");
    chk("mult plan lo", o, 32'hFFFFFFFA);
    chk("mult plan hi", oh, 32'hFFFFFFFF);
    run(5'd16, 32'hFFFFFFFF, 32'd2, "multu");
    chk("multu plan hi", oh, 1);
    run(5'd13, -32'sd7, 32'd2, "div");
    chk("div plan lo", o, 32'hFFFFFFFD);
    chk("div plan hi", oh, 32'hFFFFFFFF);
    run(5'd17, 32'd9, 32'd0, "divu0");
    run(5'd13, 32'h80000000, 32'hFFFFFFFF, "divovf");
    run(5'd13, -32'sd20, 32'd0, "div0");
    run(5'd15, 32'd0, 32'h1234ABCD, "lui");
    run(5'd14, 32'd35, 32'h80000000, "sra");

    for (int i = 0; i < 40; i++) begin
      ro = 5'($urandom_range(0, 21));
      rx = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      ry = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 3) == 0) ry = -ry;
      run(ro, rx, ry, "rand");
    end

    // next op held by the requester is accepted at the edge ending the mul result cycle
    iv = 1; op = 5'd12; a = 3; b = 5;
    @(posedge clk); @(negedge clk);
    op = 5'd8; a = 1; b = 2;
    cyc = 1;
    while (!ov && cyc < 40) begin @(negedge clk); cyc++; end
    chk("cad mul latency", cyc, 33);
    chk("cad mul out", o, 15);
    chk("cad mul ready", ir, 1);
    @(negedge clk);
    iv = 0;
    chk("cad add valid", ov, 1);
    chk("cad add out", o, 3);

    iv = 1; op = 5'd13; a = 100; b = 7;
    @(posedge clk); @(negedge clk);
    iv = 0;
    repeat (9) @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid rst out", o, 0);
    chk("mid rst out_hi", oh, 0);
    chk("mid rst ready", ir, 1);
    chk("mid rst valid", ov, 0);
    #1 rst_n = 1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (ov) seen++; end
    chk("mid rst no stale valid", seen, 0);
    chk("mid rst ready after", ir, 1);

    chk("x8 ready", ir8, 1);
    iv8 = 1; op8 = 5'd12; a8 = 8'h7F; b8 = 8'h7F;
    @(posedge clk); @(negedge clk);
    iv8 = 0;
    cyc = 1;
    while (!ov8 && cyc < 20) begin @(negedge clk); cyc++; end
    chk("x8 mult latency", cyc, 9);
    chk("x8 mult out", o8, 8'h01);
    chk("x8 mult out_hi", oh8, 8'h3F);
    @(negedge clk);
    iv8 = 1; op8 = 5'd20; a8 = 5; b8 = 6;
    @(posedge clk); @(negedge clk);
    iv8 = 0;
    chk("x8 op20 valid", ov8, 1);
    chk("x8 op20 out", o8, 0);
    chk("x8 op20 out_hi", oh8, 0);
    chk("x8 op20 zero", z8, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
